// File: rtl/bsg_1_to_n_tagged_fifo_bank.sv
// Bank of independent per-channel FIFOs fed by a one-hot tagged demux.
// Each channel buffers up to els_p words. Ready, valid and head data are decoded from registered state.
module bsg_1_to_n_tagged_fifo_bank #(
  parameter int unsigned num_out_p = 64,
  parameter int unsigned width_p   = 32,
  parameter int unsigned els_p     = 2
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic [num_out_p-1:0]           v_i,
  input  logic [width_p-1:0]             data_i,
  output logic [num_out_p-1:0]           ready_o,
  output logic [num_out_p-1:0]           v_o,
  output logic [num_out_p*width_p-1:0]   data_o,
  input  logic [num_out_p-1:0]           yumi_i,
  output logic                           any_v_o
);

  localparam int unsigned ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1);
  localparam logic [ptr_w_lp-1:0] ptr_last_lp = ptr_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0] cnt_full_lp = cnt_w_lp'(els_p);

  for (genvar k = 0; k < num_out_p; k++) begin : g_ch
    logic [width_p-1:0]  mem_r [els_p];
    logic [ptr_w_lp-1:0] wptr_r, rptr_r, wptr_n, rptr_n;
    logic [cnt_w_lp-1:0] count_r, count_n;
    logic                enq, deq;

    assign ready_o[k] = (count_r != cnt_full_lp);
    assign v_o[k]     = (count_r != '0);
    assign data_o[k*width_p +: width_p] = mem_r[rptr_r];

    assign enq = v_i[k] & ready_o[k];
    assign deq = yumi_i[k] & v_o[k];

    // Next-state for pointers and occupancy; pointers wrap at els_p-1.
    always_comb begin
      wptr_n  = wptr_r;
      rptr_n  = rptr_r;
      count_n = count_r;
      if (enq) begin
        wptr_n = (wptr_r == ptr_last_lp) ? '0 : wptr_r + ptr_w_lp'(1);
      end
      if (deq) begin
        rptr_n = (rptr_r == ptr_last_lp) ? '0 : rptr_r + ptr_w_lp'(1);
      end
      case ({enq, deq})
        2'b10:   count_n = count_r + cnt_w_lp'(1);
        2'b01:   count_n = count_r - cnt_w_lp'(1);
        default: count_n = count_r;
      endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        wptr_r  <= '0;
        rptr_r  <= '0;
        count_r <= '0;
      end else begin
        wptr_r  <= wptr_n;
        rptr_r  <= rptr_n;
        count_r <= count_n;
      end
    end

    // Storage is deliberately left unreset; data_o is only meaningful while v_o is set.
    always_ff @(posedge clk_i) begin
      if (enq) begin
        mem_r[wptr_r] <= data_i;
      end
    end
  end

  assign any_v_o = |v_o;

  // Protocol checks on the upstream demux and downstream consumer.
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert ($onehot0(v_i))
        else $error("bsg_1_to_n_tagged_fifo_bank: multiple v_i bits set %b", v_i);
      assert ((yumi_i & ~v_o) == '0)
        else $error("bsg_1_to_n_tagged_fifo_bank: yumi_i on empty channel %b", yumi_i & ~v_o);
    end
  end

endmodule

// File: tb/tb_bsg_1_to_n_tagged_fifo_bank.sv
// Directed self-checking bench for bsg_1_to_n_tagged_fifo_bank.
// Uses a 2-deep bank and a 3-deep bank on a shared clock and reset.
module tb_bsg_1_to_n_tagged_fifo_bank;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [3:0]  v_a, ready_a, vo_a, yumi_a;
  logic [7:0]  data_a;
  logic [31:0] do_a;
  logic        any_a;

  logic [3:0]  v_b, ready_b, vo_b, yumi_b;
  logic [7:0]  data_b;
  logic [31:0] do_b;
  logic        any_b;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  bsg_1_to_n_tagged_fifo_bank #(.num_out_p(4), .width_p(8), .els_p(2)) u_dut (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_a), .data_i(data_a),
    .ready_o(ready_a), .v_o(vo_a), .data_o(do_a), .yumi_i(yumi_a), .any_v_o(any_a)
  );

  bsg_1_to_n_tagged_fifo_bank #(.num_out_p(4), .width_p(8), .els_p(3)) u_dut3 (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_b), .data_i(data_b),
    .ready_o(ready_b), .v_o(vo_b), .data_o(do_b), .yumi_i(yumi_b), .any_v_o(any_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    v_a = '0; yumi_a = '0; data_a = '0;
    v_b = '0; yumi_b = '0; data_b = '0;
    #12;
    rst_n = 1'b1;
    step();

    // Reset state
    check("rst_v_o",     32'(vo_a),    32'h0);
    check("rst_ready_o", 32'(ready_a), 32'hF);
    check("rst_any_v_o", 32'(any_a),   32'h0);
    check("rst_b_ready", 32'(ready_b), 32'hF);

    // Single enqueue to ch2, then fill it
    v_a = 4'b0100; data_a = 8'hA5;
    step();
    v_a = '0;
    check("enq1_v_o",   32'(vo_a),        32'h4);
    check("enq1_head",  32'(do_a[23:16]), 32'hA5);
    check("enq1_any",   32'(any_a),       32'h1);
    check("enq1_ready", 32'(ready_a),     32'hF);
    v_a = 4'b0100; data_a = 8'h3C;
    step();
    v_a = '0;
    check("full_ready", 32'(ready_a),     32'hB);
    check("full_head",  32'(do_a[23:16]), 32'hA5);

    // Enqueue while full with simultaneous yumi: word must be refused
    v_a = 4'b0100; data_a = 8'h77; yumi_a = 4'b0100;
    step();
    v_a = '0; yumi_a = '0;
    check("blk_head",  32'(do_a[23:16]), 32'h3C);
    check("blk_ready", 32'(ready_a),     32'hF);
    check("blk_v_o",   32'(vo_a),        32'h4);
    v_a = 4'b0100; data_a = 8'h77;
    step();
    v_a = '0;
    check("re_enq_ready", 32'(ready_a),     32'hB);
    check("re_enq_head",  32'(do_a[23:16]), 32'h3C);
    yumi_a = 4'b0100;
    step();
    check("deq_77_head", 32'(do_a[23:16]), 32'h77);
    check("deq_77_v_o",  32'(vo_a),        32'h4);
    step();
    yumi_a = '0;
    check("drain_v_o", 32'(vo_a),  32'h0);
    check("drain_any", 32'(any_a), 32'h0);

    // Streaming through a 3-deep channel with wrap-around
    v_b = 4'b0010; data_b = 8'd0;
    step();
    for (int i = 1; i < 10; i++) begin
      v_b = 4'b0010; data_b = 8'(i); yumi_b = 4'b0010;
      check($sformatf("stream_head_%0d", i - 1), 32'(do_b[15:8]), 32'(i - 1));
      check($sformatf("stream_ready_%0d", i - 1), 32'(ready_b), 32'hF);
      step();
    end
    v_b = '0; yumi_b = 4'b0010;
    check("stream_head_9", 32'(do_b[15:8]), 32'd9);
    check("stream_v_o",    32'(vo_b),       32'h2);
    step();
    yumi_b = '0;
    check("stream_empty", 32'(vo_b), 32'h0);

    // Full ch0 must not block ch3
    v_a = 4'b0001; data_a = 8'hD0;
    step();
    data_a = 8'hD1;
    step();
    v_a = '0;
    check("ch0_full_ready", 32'(ready_a), 32'hE);
    v_a = 4'b1000; data_a = 8'h11;
    step();
    v_a = '0;
    check("iso_v_o",     32'(vo_a),        32'h9);
    check("iso_ch3",     32'(do_a[31:24]), 32'h11);
    check("iso_ch0",     32'(do_a[7:0]),   32'hD0);
    check("iso_ready",   32'(ready_a),     32'hE);

    // Asynchronous reset mid-cycle discards buffered words immediately
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_v_o",   32'(vo_a),    32'h0);
    check("arst_ready", 32'(ready_a), 32'hF);
    check("arst_any",   32'(any_a),   32'h0);
    #1;
    rst_n = 1'b1;
    step();
    check("post_rst_v_o",   32'(vo_a),    32'h0);
    check("post_rst_ready", 32'(ready_a), 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
